keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
- Keypad front-end controller for the calculator datapath; the next generation of the keypad state machine.
- Decodes 5-bit key codes into digit writes, operand selection and operation requests.
- Enforces a release/hold time of WAIT_CYCLES clocks after every accepted key.
- Generalised to N operands and DIGITS digits per operand, with digit-overflow detection and a start/done handshake to the ALU.

Parameters:
- WAIT_CYCLES, 10000, minimum hold cycles after an accepted key before release is checked; must be >= 1.
- DIGITS, 4, maximum digits stored per operand; must be >= 1.
- N_OPERANDS, 2, number of operand registers cycled by key 0x0A; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key  in  5  key code: 0x00-0x09 digit, 0x0A select, 0x0B-0x0F op, 0x1F none, 0x10-0x1E invalid.
- op_done  in  1  ALU completion; level or pulse.
- state  out  2  0 IDLE, 1 HOLD, 2 HOLD_OP, 3 EXEC.
- operand_sel  out  max(1,clog2(N_OPERANDS))  active operand.
- digit_idx  out  clog2(DIGITS+1)  digits entered into the active operand.
- digit_we  out  1  one-cycle digit write strobe.
- digit_val  out  4  digit value; valid when digit_we=1.
- digit_pos  out  clog2(DIGITS+1)  write position; valid when digit_we=1.
- op_code  out  3  0 none, 1 ADD (0x0B), 2 SUB (0x0C), 3 AND (0x0D), 4 OR (0x0E), 5 XOR (0x0F).
- op_start  out  1  one-cycle ALU start pulse.
- overflow  out  1  one-cycle pulse when a digit arrives with digit_idx==DIGITS.

Behaviour:
Reset and output timing:
- Reset is sampled only on a clk edge and overrides all other inputs.
- Reset values: state=IDLE, operand_sel=0, digit_idx=0, op_code=0, hold counter=0, done flag=0, and all of digit_we, digit_val, digit_pos, op_start and overflow = 0.
- Reset mid-operation (any state, including EXEC): the same values; an outstanding op_done is then ignored.
- All outputs are registered; digit_we, op_start and overflow are high for exactly one cycle.

IDLE (keys sampled every cycle):
- Digit key, digit_idx<DIGITS: digit_we=1, digit_val=key[3:0], digit_pos=digit_idx; digit_idx increments; go to HOLD.
- Digit key, digit_idx==DIGITS: overflow=1, no write, digit_idx unchanged; go to HOLD.
- Key 0x0A: operand_sel increments, wrapping N_OPERANDS-1 -> 0; digit_idx=0; go to HOLD.
- Keys 0x0B-0x0F: op_code set per the encoding; operand_sel=0; digit_idx=0; go to HOLD_OP.
- 0x1F or invalid codes: no effect, stay in IDLE.

HOLD / HOLD_OP (hold and release):
- Hold counter (width clog2(WAIT_CYCLES)+1) increments each cycle.
- On the cycle the counter equals WAIT_CYCLES-1, it clears to 0, then:
  - key==0x1F: HOLD goes to IDLE; HOLD_OP goes to EXEC.
  - otherwise: stay and restart the count (a held key is never re-accepted).
- With WAIT_CYCLES=1 the release check happens every cycle.

Entering EXEC:
- op_start=1 in the first EXEC cycle.
- The done flag is cleared on entry.

EXEC:
- op_done is sampled every EXEC cycle, including the op_start cycle, and sets the done flag.
- Exit to IDLE when (done flag | op_done) and key==0x1F.
- op_code holds its value until the next op key; it is cleared only by reset.
- Keys pressed during EXEC are ignored. After exit, a still-held key is not accepted until it reads 0x1F in IDLE: an IDLE edge-detect flag requires one 0x1F sample before any key is accepted after EXEC.

Arithmetic and simultaneity:
- Counters never saturate silently: digit_idx stops at DIGITS and signals overflow instead.
- op_done in IDLE, HOLD or HOLD_OP is ignored.
- A key and rst in the same cycle: reset wins.

Test Plan:
- WAIT_CYCLES=4, DIGITS=2, N_OPERANDS=3. After reset, all outputs hold reset values; key=0x1F for 10 cycles -> state stays 0, no strobes.
- Key 0x07 for 1 cycle, then 0x1F -> digit_we=1 for exactly one cycle with digit_val=7, digit_pos=0; digit_idx=1; state=1 for 4 cycles, then 0.
- Three digit presses 3, 5, 9, each released -> writes at pos 0 and 1; third press gives overflow=1 and digit_we=0; digit_idx stays 2.
- Key 0x0A pressed 3 times, each released -> operand_sel goes 1, 2, 0; digit_idx=0 after each press.
- Key 0x0C held 10 cycles -> state=2 throughout the hold with no re-accept; after release, op_start pulses once and op_code=2; op_done asserted in the op_start cycle while key=0x1F -> state returns to 0 on the next cycle.
- In EXEC, op_done pulses while key 0x05 is held, then released -> stay in EXEC until release, then IDLE with no digit_we; rst asserted in EXEC -> state=0, op_code=0 on the next edge.

Source files
------------

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad controller signal bundle: key/op_done toward the controller,
// decoded strobes and status back out. The controller takes the slave side.
interface keypad_entry_ctrl_if #(
  parameter int SEL_W = 1,
  parameter int IDX_W = 3
);
  logic [4:0]       key;
  logic             op_done;
  logic [1:0]       state;
  logic [SEL_W-1:0] operand_sel;
  logic [IDX_W-1:0] digit_idx;
  logic             digit_we;
  logic [3:0]       digit_val;
  logic [IDX_W-1:0] digit_pos;
  logic [2:0]       op_code;
  logic             op_start;
  logic             overflow;

  modport master (
    output key, op_done,
    input  state, operand_sel, digit_idx, digit_we, digit_val, digit_pos,
           op_code, op_start, overflow
  );

  modport slave (
    input  key, op_done,
    output state, operand_sel, digit_idx, digit_we, digit_val, digit_pos,
           op_code, op_start, overflow
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad front-end: decodes key codes into digit writes, operand selection and
// ALU requests, with a hold/release interval after every accepted key.
module keypad_entry_ctrl #(
  parameter int WAIT_CYCLES = 10000,
  parameter int DIGITS      = 4,
  parameter int N_OPERANDS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  keypad_entry_ctrl_if.slave  bus
);
  localparam int SEL_W = ($clog2(N_OPERANDS) > 1) ? $clog2(N_OPERANDS) : 1;
  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;

  localparam logic [4:0]       KEY_NONE = 5'h1F;
  localparam logic [4:0]       KEY_SEL  = 5'h0A;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_OPERANDS - 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_HOLD_OP = 2'd2,
    S_EXEC    = 2'd3
  } state_t;

  state_t           r_state,   w_state;
  logic [SEL_W-1:0] r_sel,     w_sel;
  logic [IDX_W-1:0] r_idx,     w_idx;
  logic [CNT_W-1:0] r_cnt,     w_cnt;
  logic             r_done,    w_done;
  logic             r_armed,   w_armed;
  logic             r_we,      w_we;
  logic [3:0]       r_val,     w_val;
  logic [IDX_W-1:0] r_pos,     w_pos;
  logic [2:0]       r_op_code, w_op_code;
  logic             r_start,   w_start;
  logic             r_ovf,     w_ovf;
  logic             w_key_none;

  assign w_key_none = (bus.key == KEY_NONE);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state   = r_state;
    w_sel     = r_sel;
    w_idx     = r_idx;
    w_cnt     = r_cnt;
    w_done    = r_done;
    w_armed   = r_armed;
    w_op_code = r_op_code;
    w_we      = 1'b0;
    w_val     = 4'd0;
    w_pos     = '0;
    w_start   = 1'b0;
    w_ovf     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // After EXEC a key is accepted only once the pad has read "none" here.
        if (!r_armed) begin
          if (w_key_none) w_armed = 1'b1;
        end else if (bus.key <= 5'h09) begin
          if (r_idx < IDX_FULL) begin
            w_we  = 1'b1;
            w_val = bus.key[3:0];
            w_pos = r_idx;
            w_idx = r_idx + 1'b1;
          end else begin
            w_ovf = 1'b1;
          end
          w_cnt   = '0;
          w_state = S_HOLD;
        end else if (bus.key == KEY_SEL) begin
          w_sel   = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
          w_idx   = '0;
          w_cnt   = '0;
          w_state = S_HOLD;
        end else if (bus.key <= 5'h0F) begin
          w_op_code = 3'(bus.key - KEY_SEL);
          w_sel     = '0;
          w_idx     = '0;
          w_cnt     = '0;
          w_state   = S_HOLD_OP;
        end
      end

      S_HOLD, S_HOLD_OP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt = '0;
          if (w_key_none) begin
            if (r_state == S_HOLD) begin
              w_state = S_IDLE;
            end else begin
              w_state = S_EXEC;
              w_start = 1'b1;
              w_done  = 1'b0;
            end
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_EXEC: begin
        if (bus.op_done) w_done = 1'b1;
        if ((r_done || bus.op_done) && w_key_none) begin
          w_state = S_IDLE;
          w_armed = 1'b0;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_armed   <= 1'b1;
      r_we      <= 1'b0;
      r_val     <= 4'd0;
      r_pos     <= '0;
      r_op_code <= 3'd0;
      r_start   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_sel     <= w_sel;
      r_idx     <= w_idx;
      r_cnt     <= w_cnt;
      r_done    <= w_done;
      r_armed   <= w_armed;
      r_we      <= w_we;
      r_val     <= w_val;
      r_pos     <= w_pos;
      r_op_code <= w_op_code;
      r_start   <= w_start;
      r_ovf     <= w_ovf;
    end
  end

  assign bus.state       = r_state;
  assign bus.operand_sel = r_sel;
  assign bus.digit_idx   = r_idx;
  assign bus.digit_we    = r_we;
  assign bus.digit_val   = r_val;
  assign bus.digit_pos   = r_pos;
  assign bus.op_code     = r_op_code;
  assign bus.op_start    = r_start;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: a behavioural model built from the key
// rules is compared against the outputs every cycle, with literal pins on the model.
module tb_keypad_entry_ctrl;
  localparam int WAIT = 4;
  localparam int DIG  = 2;
  localparam int NOP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_entry_ctrl_if #(.SEL_W(2), .IDX_W(2)) bus ();

  keypad_entry_ctrl #(
    .WAIT_CYCLES (WAIT),
    .DIGITS      (DIG),
    .N_OPERANDS  (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode follows the output encoding, digits live in a queue
  int m_state, m_sel, m_age, m_op;
  bit m_done, m_armed, m_we, m_start, m_ovf;
  int m_val, m_pos;
  int digs[$];

  always @(posedge clk) begin
    int k;
    k = int'(bus.key);
    m_we = 0; m_val = 0; m_pos = 0; m_start = 0; m_ovf = 0;
    if (rst) begin
      m_state = 0; m_sel = 0; m_age = 0; m_op = 0;
      m_done = 0; m_armed = 1; digs.delete();
    end else begin
      case (m_state)
        0: begin
          if (!m_armed) begin
            if (k == 31) m_armed = 1;
          end else if (k < 10) begin
            if (digs.size() < DIG) begin
              m_we = 1; m_val = k; m_pos = digs.size(); digs.push_back(k);
            end else begin
              m_ovf = 1;
            end
            m_age = 0; m_state = 1;
          end else if (k == 10) begin
            m_sel = (m_sel + 1) % NOP; digs.delete(); m_age = 0; m_state = 1;
          end else if (k <= 15) begin
            m_op = k - 10; m_sel = 0; digs.delete(); m_age = 0; m_state = 2;
          end
        end
        1, 2: begin
          if ((m_age % WAIT) == WAIT - 1 && k == 31) begin
            if (m_state == 2) begin
              m_start = 1; m_done = 0;
            end
            m_state = (m_state == 1) ? 0 : 3;
          end
          m_age++;
        end
        default: begin
          if (bus.op_done) m_done = 1;
          if (m_done && k == 31) begin
            m_state = 0; m_armed = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",       bus.state,       m_state);
      check("operand_sel", bus.operand_sel, m_sel);
      check("digit_idx",   bus.digit_idx,   digs.size());
      check("digit_we",    bus.digit_we,    m_we);
      check("op_code",     bus.op_code,     m_op);
      check("op_start",    bus.op_start,    m_start);
      check("overflow",    bus.overflow,    m_ovf);
      if (m_we) begin
        check("digit_val", bus.digit_val, m_val);
        check("digit_pos", bus.digit_pos, m_pos);
      end
    end
  end

  task automatic tick(input logic [4:0] k, input logic d = 1'b0, input logic r = 1'b0);
    bus.key     = k;
    bus.op_done = d;
    rst         = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(5'h1F);
  endtask

  task automatic wait_exec(input string name);
    int guard = 0;
    while (m_state != 3 && guard < 30) begin
      tick(5'h1F);
      guard++;
    end
    check(name, m_state, 3);
  endtask

  initial begin
    bus.key     = 5'h1F;
    bus.op_done = 1'b0;
    tick(5'h1F, 1'b0, 1'b1);
    tick(5'h1F, 1'b0, 1'b1);
    chk_en = 1'b1;
    idle(10);
    check("pin_reset_state", m_state, 0);

    tick(5'h10); tick(5'h1E); tick(5'h15);
    check("pin_invalid_idle", m_state, 0);

    tick(5'h07);
    check("pin_d7_we", m_we, 1);
    check("pin_d7_val", m_val, 7);
    check("pin_d7_state", m_state, 1);
    idle(3);
    check("pin_d7_still_hold", m_state, 1);
    idle(1);
    check("pin_d7_released", m_state, 0);
    check("pin_d7_idx", digs.size(), 1);
    idle(2);

    tick(5'h1F, 1'b0, 1'b1);
    idle(2);
    tick(5'h03); check("pin_d3_pos", m_pos, 0); idle(6);
    tick(5'h05); check("pin_d5_pos", m_pos, 1); idle(6);
    tick(5'h09);
    check("pin_d9_ovf", m_ovf, 1);
    check("pin_d9_we", m_we, 0);
    check("pin_d9_idx", digs.size(), 2);
    idle(6);

    tick(5'h0A); check("pin_sel_1", m_sel, 1); idle(6);
    tick(5'h0A); check("pin_sel_2", m_sel, 2); idle(6);
    tick(5'h0A); check("pin_sel_0", m_sel, 0);
    check("pin_sel_idx", digs.size(), 0);
    idle(6);

    // SUB held for 10 cycles with a stray op_done during the hold
    for (int i = 0; i < 10; i++) tick(5'h0C, (i == 5));
    check("pin_sub_hold", m_state, 2);
    wait_exec("sub_reach_exec");
    check("pin_sub_start", m_start, 1);
    check("pin_sub_code", m_op, 2);
    tick(5'h1F, 1'b1);
    check("pin_sub_exit", m_state, 0);

    idle(2);
    tick(5'h0B); idle(1);
    wait_exec("add_reach_exec");
    tick(5'h05); tick(5'h05); tick(5'h05, 1'b1); tick(5'h05); tick(5'h05);
    check("pin_exec_held", m_state, 3);
    tick(5'h1F);
    check("pin_exec_exit", m_state, 0);
    tick(5'h05);
    check("pin_unarmed_we", m_we, 0);
    check("pin_unarmed_state", m_state, 0);
    tick(5'h1F);
    tick(5'h05);
    check("pin_armed_we", m_we, 1);
    check("pin_add_code", m_op, 1);
    idle(6);

    tick(5'h0D); idle(1);
    wait_exec("and_reach_exec");
    idle(2);
    tick(5'h05, 1'b1, 1'b1);
    check("pin_rst_exec_state", m_state, 0);
    check("pin_rst_exec_code", m_op, 0);
    tick(5'h1F, 1'b1);
    tick(5'h1F, 1'b1);
    idle(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
